// File: rtl/seq_scheduler_if.sv
// ---------------------------------------------------------------------------
// seq_scheduler_if
// Bundle of the host byte bus, the run controls and the sequencing outputs
// of seq_scheduler.
//   master : host / controller side (drives wr, dato, Stb, start, stop,
//            mode, dwell; observes everything else)
//   slave  : seq_scheduler side
// Signals:
//   wr, dato, Stb     host byte bus (load window, data byte, byte strobe)
//   start, stop       run/advance pulse, abort pulse
//   mode, dwell       run mode and per-entry dwell, latched at run start
//   cfg_out, seq_en   applied config word and its one-cycle apply strobe
//   busy, done        activity flag and end-of-run pulse
//   entry_idx         index of the entry being applied
//   n_entries         number of words loaded
//   overflow          sticky "byte arrived while table full"
//   state_dbg         current scheduler state, for observation only
//
// Handshake: the host byte bus has no ready. dato is valid on the cycle in
// which Stb rises while wr is high; the scheduler takes it only in IDLE.
// Bytes that arrive outside IDLE are ignored, bytes beyond a full table are
// dropped and flagged on overflow. seq_en is a one-cycle valid qualifying
// cfg_out towards the secuenciador, which must always accept it.
// ---------------------------------------------------------------------------
interface seq_scheduler_if #(
    parameter int CFG_W   = 16,
    parameter int DWELL_W = 16,
    parameter int IDX_W   = 3
);
    logic               wr;
    logic [7:0]         dato;
    logic               Stb;
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [CFG_W-1:0]   cfg_out;
    logic               seq_en;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   entry_idx;
    logic [IDX_W:0]     n_entries;
    logic               overflow;
    logic [2:0]         state_dbg;

    modport master (
        output wr, dato, Stb, start, stop, mode, dwell,
        input  cfg_out, seq_en, busy, done, entry_idx, n_entries, overflow,
               state_dbg
    );

    modport slave (
        input  wr, dato, Stb, start, stop, mode, dwell,
        output cfg_out, seq_en, busy, done, entry_idx, n_entries, overflow,
               state_dbg
    );
endinterface

// File: rtl/seq_scheduler.sv
// ---------------------------------------------------------------------------
// seq_scheduler
// Configuration and sequencing controller in front of the secuenciador.
// Packs host bytes (low byte first) into CFG_W-bit words held in a DEPTH
// entry table, then on start steps through the table: each entry is put on
// cfg_out (APPLY), strobed with seq_en (STROBE), held for max(dwell,1)
// cycles (DWELL) and then the next entry is chosen (NEXT / WAIT).
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset (table contents are kept)
//   bus    seq_scheduler_if.slave, see the interface for signal list
// ---------------------------------------------------------------------------
module seq_scheduler #(
    parameter int DEPTH   = 8,
    parameter int CFG_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL      = (IDX_W+1)'(DEPTH);
    localparam logic [1:0]     MODE_STEP = 2'b00;
    localparam logic [1:0]     MODE_LOOP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_STROBE = 3'd2,
        S_DWELL  = 3'd3,
        S_NEXT   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t             state, state_d;

    // load path
    logic               stb_q, wr_q;
    logic [7:0]         low_byte;
    logic               phase, phase_d;
    logic [IDX_W:0]     n_entries_q, n_d;
    logic               overflow_q, ovf_d;
    logic               low_we, tbl_we;
    logic [CFG_W-1:0]   table_mem [DEPTH];

    // run path
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] dwell_q, cnt;
    logic [IDX_W-1:0]   entry_idx_q, idx_d;
    logic [CFG_W-1:0]   cfg_q;
    logic               done_pend, done_q;
    logic               seq_en_c, busy_c, finish_c, load_cfg_c;

    logic is_idle, accept, wr_rise, wr_fall, last, start_ok;

    assign is_idle  = (state == S_IDLE);
    assign accept   = bus.Stb & ~stb_q & bus.wr & is_idle;
    assign wr_rise  = bus.wr & ~wr_q & is_idle;
    assign wr_fall  = ~bus.wr & wr_q;
    assign last     = ({1'b0, entry_idx_q} == (n_entries_q - 1'b1));
    assign start_ok = bus.start & ~bus.stop & ~bus.wr & (n_entries_q != '0);

    // ---------------- byte packing ----------------
    always_comb begin
        n_d     = n_entries_q;
        phase_d = phase;
        ovf_d   = overflow_q;
        low_we  = 1'b0;
        tbl_we  = 1'b0;
        if (wr_rise) begin
            n_d     = '0;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (wr_fall) begin
            // an unpaired low byte is abandoned when the window closes
            phase_d = 1'b0;
        end
        if (accept) begin
            if (n_d == FULL) begin
                ovf_d = 1'b1;
            end else if (!phase_d) begin
                phase_d = 1'b1;
                low_we  = 1'b1;
            end else begin
                phase_d = 1'b0;
                tbl_we  = 1'b1;
                n_d     = n_d + 1'b1;
            end
        end
    end

    // Table is deliberately outside reset so a reset does not lose the
    // loaded configuration.
    always_ff @(posedge clk) begin
        if (rst_n && low_we)
            low_byte <= bus.dato;
        if (rst_n && tbl_we)
            table_mem[n_entries_q[IDX_W-1:0]] <= CFG_W'({bus.dato, low_byte});
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (start_ok) state_d = S_APPLY;
            S_APPLY:  state_d = S_STROBE;
            S_STROBE: state_d = S_DWELL;
            // cnt starts at dwell; <=1 also covers dwell=0 as one cycle
            S_DWELL:  if (cnt <= DWELL_W'(1)) state_d = S_NEXT;
            S_NEXT: begin
                if (last)
                    state_d = (mode_q == MODE_LOOP) ? S_APPLY : S_IDLE;
                else
                    state_d = (mode_q == MODE_STEP) ? S_WAIT : S_APPLY;
            end
            S_WAIT:   if (bus.start) state_d = S_APPLY;
            default:  state_d = S_IDLE;
        endcase
        // abort wins over everything, including a same-cycle start
        if (bus.stop && state != S_IDLE)
            state_d = S_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_c     = (state != S_IDLE);
        seq_en_c   = (state == S_STROBE) && !bus.stop;
        finish_c   = (state == S_NEXT) && last && (mode_q != MODE_LOOP) && !bus.stop;
        load_cfg_c = (state_d == S_APPLY);
        idx_d      = entry_idx_q;
        if (state == S_IDLE && state_d == S_APPLY)
            idx_d = '0;
        else if (state == S_NEXT && state_d != S_IDLE)
            idx_d = last ? '0 : entry_idx_q + 1'b1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_q       <= 1'b0;
            wr_q        <= 1'b0;
            phase       <= 1'b0;
            n_entries_q <= '0;
            overflow_q  <= 1'b0;
            mode_q      <= '0;
            dwell_q     <= '0;
            cnt         <= '0;
            entry_idx_q <= '0;
            cfg_q       <= '0;
            done_pend   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            stb_q       <= bus.Stb;
            wr_q        <= bus.wr;
            phase       <= phase_d;
            n_entries_q <= n_d;
            overflow_q  <= ovf_d;
            if (state == S_IDLE && state_d == S_APPLY) begin
                mode_q  <= bus.mode;
                dwell_q <= bus.dwell;
            end
            entry_idx_q <= idx_d;
            // cfg_out takes the new word on entry to APPLY, so it is already
            // stable for a full cycle when seq_en fires in STROBE
            if (load_cfg_c)
                cfg_q <= table_mem[idx_d];
            if (state == S_STROBE)
                cnt <= dwell_q;
            else if (state == S_DWELL && cnt != '0)
                cnt <= cnt - DWELL_W'(1);
            // done lands one full entry period after the final seq_en,
            // i.e. in the slot where the next strobe would have been
            done_pend <= finish_c;
            done_q    <= done_pend;
        end
    end

    assign bus.cfg_out   = cfg_q;
    assign bus.seq_en    = seq_en_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_q;
    assign bus.entry_idx = entry_idx_q;
    assign bus.n_entries = n_entries_q;
    assign bus.overflow  = overflow_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_seq_scheduler.sv
module tb_seq_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_scheduler_if #(.CFG_W(16), .DWELL_W(16), .IDX_W(3)) bus ();

    seq_scheduler #(.DEPTH(8), .CFG_W(16), .DWELL_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int both_seen = 0;
    int busy_seen = 0;

    // scoreboard: seq_en events as {cycle, index, cfg word}
    logic [55:0] exp_q[$];
    logic [55:0] act_q[$];
    int          exp_done[$];
    int          act_done[$];

    // reference model of the table loader
    logic [15:0] ref_tbl[8];
    int          ref_n = 0;
    bit          ref_ovf = 1'b0;
    bit          ref_phase = 1'b0;
    logic [7:0]  ref_low = 8'h00;
    logic [7:0]  byte_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.seq_en === 1'b1)
            act_q.push_back({32'(cyc), 8'(bus.entry_idx), bus.cfg_out});
        if (bus.done === 1'b1)
            act_done.push_back(cyc);
        if (bus.seq_en === 1'b1 && bus.done === 1'b1)
            both_seen++;
        if (bus.busy === 1'b1)
            busy_seen++;
    endtask

    function automatic void m_wr_rise();
        ref_n = 0;
        ref_phase = 1'b0;
        ref_ovf = 1'b0;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        if (ref_n == 8) begin
            ref_ovf = 1'b1;
        end else if (!ref_phase) begin
            ref_low = b;
            ref_phase = 1'b1;
        end else begin
            ref_tbl[ref_n] = {b, ref_low};
            ref_n++;
            ref_phase = 1'b0;
        end
    endfunction

    // one complete load window carrying the bytes in byte_q
    task automatic load_session(input string tag);
        bus.wr = 1'b1;
        m_wr_rise();
        step();
        foreach (byte_q[i]) begin
            bus.dato = byte_q[i];
            bus.Stb = 1'b1;
            step();
            m_byte(byte_q[i]);
            bus.Stb = 1'b0;
            step();
        end
        bus.wr = 1'b0;
        ref_phase = 1'b0;
        step();
        step();
        chk({tag, "_n_entries"}, 64'(bus.n_entries), 64'(ref_n));
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(ref_ovf));
    endtask

    task automatic load_rand(input string tag, input int words, input int extra);
        byte_q = {};
        for (int i = 0; i < 2 * words + extra; i++)
            byte_q.push_back(8'($urandom_range(0, 255)));
        load_session(tag);
    endtask

    task automatic do_start(input logic [1:0] m, input int d, output int c);
        bus.mode = m;
        bus.dwell = 16'(d);
        bus.start = 1'b1;
        c = cyc;
        step();
        bus.start = 1'b0;
    endtask

    function automatic int period(input int d);
        return ((d == 0) ? 1 : d) + 3;
    endfunction

    // pulse k of a run started at cycle c lands at c + 2 + k*period
    function automatic void expect_pulses(input int c, input int d, input int first_k, input int npulses);
        for (int k = first_k; k < first_k + npulses; k++)
            exp_q.push_back({32'(c + 2 + (k - first_k) * period(d)), 8'(k % ref_n), ref_tbl[k % ref_n]});
    endfunction

    task automatic compare_logs(input string tag);
        chk({tag, "_pulse_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < act_q.size())
                chk({tag, "_pulse"}, 64'(act_q[i]), 64'(exp_q[i]));
        chk({tag, "_done_count"}, 64'(act_done.size()), 64'(exp_done.size()));
        foreach (exp_done[i])
            if (i < act_done.size())
                chk({tag, "_done_cycle"}, 64'(act_done[i]), 64'(exp_done[i]));
        exp_q = {};
        act_q = {};
        exp_done = {};
        act_done = {};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, n, d;
        logic [1:0] m;

        bus.wr = 1'b0;
        bus.dato = 8'h00;
        bus.Stb = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mode = 2'b00;
        bus.dwell = 16'd0;

        // ---- clock / reset ----
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_seq_en", 64'(bus.seq_en), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_cfg_out", 64'(bus.cfg_out), 64'd0);
        chk("rst_entry_idx", 64'(bus.entry_idx), 64'd0);
        chk("rst_n_entries", 64'(bus.n_entries), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        step();

        // ---- directed load of two words ----
        byte_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        load_session("load2");

        // ---- 17 bytes: table full, last byte dropped ----
        load_rand("load17", 8, 1);
        bus.wr = 1'b1;
        m_wr_rise();
        step();
        step();
        chk("reopen_n_entries", 64'(bus.n_entries), 64'(ref_n));
        chk("reopen_overflow", 64'(bus.overflow), 64'(ref_ovf));
        bus.wr = 1'b0;
        step();

        // ---- one-shot, dwell 5, two entries ----
        byte_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        load_session("reload2");
        do_start(2'b01, 5, c);
        chk("oneshot_apply_cfg", 64'(bus.cfg_out), 64'(ref_tbl[0]));
        chk("oneshot_apply_seq_en", 64'(bus.seq_en), 64'd0);
        while (cyc < c + 2 + 2 * period(5) + 4) step();
        expect_pulses(c, 5, 0, 2);
        exp_done.push_back(c + 2 + 2 * period(5));
        compare_logs("oneshot");
        chk("oneshot_idle_busy", 64'(bus.busy), 64'd0);

        // ---- loop, dwell 0, three entries, stop mid-dwell ----
        load_rand("load3", 3, 0);
        do_start(2'b10, 0, c);
        while (cyc < c + 3 + 4 * period(0)) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_busy", 64'(bus.busy), 64'd0);
        chk("stop_seq_en", 64'(bus.seq_en), 64'd0);
        chk("stop_cfg_held", 64'(bus.cfg_out), 64'(ref_tbl[4 % 3]));
        chk("stop_idx_held", 64'(bus.entry_idx), 64'(4 % 3));
        repeat (12) step();
        expect_pulses(c, 0, 0, 5);
        compare_logs("loop");

        // ---- randomized one-shot runs ----
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(1, 8);
            d = $urandom_range(0, 6);
            m = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
            load_rand("rand_load", n, $urandom_range(0, 1));
            do_start(m, d, c);
            while (cyc < c + 2 + n * period(d) + 4) step();
            expect_pulses(c, d, 0, n);
            exp_done.push_back(c + 2 + n * period(d));
            compare_logs("rand_oneshot");
        end

        // ---- step mode, two entries ----
        load_rand("step_load", 2, 0);
        d = $urandom_range(0, 4);
        do_start(2'b00, d, c);
        while (cyc < c + 2 + period(d) + 6) step();
        chk("step_wait_busy", 64'(bus.busy), 64'd1);
        do_start(2'b00, d, c2);
        while (cyc < c2 + 2 + period(d) + 4) step();
        exp_q.push_back({32'(c + 2), 8'd0, ref_tbl[0]});
        exp_q.push_back({32'(c2 + 2), 8'd1, ref_tbl[1]});
        exp_done.push_back(c2 + 2 + period(d));
        compare_logs("step");

        // start while the load window is open: ignored
        bus.wr = 1'b1;
        m_wr_rise();
        bus.start = 1'b1;
        busy_seen = 0;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        chk("wr_start_busy_cycles", 64'(busy_seen), 64'd0);
        chk("wr_start_n_entries", 64'(bus.n_entries), 64'(ref_n));
        compare_logs("wr_start");
        bus.wr = 1'b0;
        step();

        // ---- reset during dwell of a loop run ----
        load_rand("rst_load", 3, 0);
        d = $urandom_range(2, 6);
        do_start(2'b10, d, c);
        while (cyc < c + 3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_wr_rise();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_seq_en", 64'(bus.seq_en), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_cfg_out", 64'(bus.cfg_out), 64'd0);
        chk("midrst_entry_idx", 64'(bus.entry_idx), 64'd0);
        chk("midrst_n_entries", 64'(bus.n_entries), 64'(ref_n));
        chk("midrst_overflow", 64'(bus.overflow), 64'(ref_ovf));
        exp_q.push_back({32'(c + 2), 8'd0, ref_tbl[0]});
        compare_logs("midrst");

        busy_seen = 0;
        do_start(2'b01, 1, c);
        repeat (12) step();
        chk("empty_start_busy_cycles", 64'(busy_seen), 64'd0);
        compare_logs("empty_start");

        chk("seq_en_done_overlap", 64'(both_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
